// File: rtl/eeprom_i2c_master_if.sv
// eeprom_i2c_master_if: system-side request/response bundle of the EEPROM two-wire master.
// The master modport belongs to the controller; the slave modport belongs to whoever issues requests.
interface eeprom_i2c_master_if;
  logic        wr_req;
  logic        rd_req;
  logic [10:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic        err;
  modport master (input wr_req, rd_req, addr, wdata, output rdata, busy, done, err);
  modport slave  (output wr_req, rd_req, addr, wdata, input rdata, busy, done, err);
endinterface

// File: rtl/eeprom_i2c_master.sv
// eeprom_i2c_master: two-wire master turning single-byte write / random-read requests into EEPROM frames.
// Define EEPROM_I2C_MASTER_ACK_CHECK_EN to abort on a missing ack and raise the sticky err flag.
module eeprom_i2c_master #(
  parameter int         QTR    = 2,
  parameter logic [3:0] DEV_ID = 4'b1010
) (
  input  logic                clk,
  input  logic                rst_n,
  eeprom_i2c_master_if.master bus,
  output logic                scl_o,
  inout  wire                 sda_io
);
  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  typedef enum logic [3:0] {
    IDLE, START, CTRL_W, ADDR, DATA_W, RSTART, CTRL_R, DATA_R, STOP, DONE
  } state_t;
  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    ph_q, ph_d;
  logic [3:0]    bit_q, bit_d;
  logic          wr_q, wr_d;
  logic [10:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          oe, sdo, sda_in;
  logic          qtr_end, bit_end, byte_st, last_bit;
  assign sda_io   = oe ? sdo : 1'bz;
  assign sda_in   = sda_io;
  assign qtr_end  = qcnt_q == QW'(QTR - 1);
  assign bit_end  = qtr_end && ph_q == 2'd3;
  assign byte_st  = state_q inside {CTRL_W, ADDR, DATA_W, CTRL_R, DATA_R};
  assign last_bit = !byte_st || bit_q == 4'd8;
  assign bus.busy  = state_q != IDLE;
  assign bus.done  = state_q == DONE;
  assign bus.rdata = rdata_q;
`ifdef EEPROM_I2C_MASTER_ACK_CHECK_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  // Bit index 8 of every byte state is the ack (or, in DATA_R, the master's nack) slot.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sh_d    = sh_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (bus.wr_req || bus.rd_req) begin
        state_d = START;
        wr_d    = bus.wr_req;
        addr_d  = bus.addr;
        wdata_d = bus.wdata;
        err_d   = 1'b0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else begin
      qcnt_d = qtr_end ? '0 : qcnt_q + QW'(1);
      ph_d   = qtr_end ? ph_q + 2'd1 : ph_q;
      if (bit_end) begin
        bit_d = last_bit ? 4'd0 : bit_q + 4'd1;
        if (!last_bit) sh_d = {sh_q[6:0], sda_in};
        if (last_bit) begin
          case (state_q)
            START:   begin state_d = CTRL_W; sh_d = {DEV_ID, addr_q[10:8], 1'b0}; end
            CTRL_W:  begin state_d = ADDR;   sh_d = addr_q[7:0]; end
            ADDR:    begin state_d = wr_q ? DATA_W : RSTART; sh_d = wdata_q; end
            RSTART:  begin state_d = CTRL_R; sh_d = {DEV_ID, addr_q[10:8], 1'b1}; end
            CTRL_R:  state_d = DATA_R;
            STOP:    begin state_d = DONE; rdata_d = (wr_q || err_q) ? rdata_q : sh_q; end
            default: state_d = STOP;
          endcase
`ifdef EEPROM_I2C_MASTER_ACK_CHECK_EN
          if (byte_st && state_q != DATA_R && sda_in) begin
            state_d = STOP;
            err_d   = 1'b1;
          end
`endif
        end
      end
    end
  end
  // Repeated start raises scl one phase early so sda can fall while scl is already high.
  always_comb begin
    scl_o = 1'b1;
    oe    = 1'b0;
    sdo   = 1'b1;
    case (state_q)
      START:  begin oe = 1'b1; sdo = !ph_q[1]; end
      RSTART: begin scl_o = ph_q != 2'd0; oe = 1'b1; sdo = !ph_q[1]; end
      STOP:   begin scl_o = ph_q[1]; oe = 1'b1; sdo = ph_q == 2'd3; end
      CTRL_W, ADDR, DATA_W, CTRL_R: begin scl_o = ph_q[1]; oe = bit_q != 4'd8; sdo = sh_q[7]; end
      DATA_R: begin scl_o = ph_q[1]; oe = bit_q == 4'd8; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_eeprom_i2c_master.sv
// tb_eeprom_i2c_master: drives byte writes/reads into the two-wire master against a behavioural EEPROM
// slave on the bus, and checks timing, control bytes, memory contents and read data against a reference.
module tb_eeprom_i2c_master;
  localparam int QTR = 2;
  localparam int T   = 4 * QTR;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl;
  wire  sda;
  logic drv      = 1'b0;
  logic attached = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   starts = 0;
  int   stops  = 0;
  int   dones  = 0;
  logic [7:0] mem     [2048];
  logic [7:0] ref_mem [2048];
  logic [7:0] ctrls   [$];
  logic [7:0] last_rd = 8'h00;

  eeprom_i2c_master_if bus();
  eeprom_i2c_master #(.QTR(QTR), .DEV_ID(4'b1010)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .scl_o(scl), .sda_io(sda)
  );
  pullup (sda);
  assign sda = drv ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 4));
  endfunction

  // Behavioural serial EEPROM: samples the bus once per clk on the falling clk edge.
  initial begin
    logic cs, ds, pscl, psda, rw;
    logic [7:0] sh, rsh, word;
    logic [2:0] blk;
    int mode, bc;
    pscl = 1'b1; psda = 1'b1; rw = 1'b0; sh = '0; rsh = '0; word = '0; blk = '0; mode = 0; bc = 0;
    for (int i = 0; i < 2048; i++) mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      cs = scl; ds = sda;
      if (bus.done) dones++;
      if (pscl && cs && psda && !ds) begin
        starts++; mode = 1; bc = 0; drv = 1'b0;
      end else if (pscl && cs && !psda && ds) begin
        stops++; mode = 0; bc = 0; drv = 1'b0;
      end else if (mode != 0 && !pscl && cs) begin
        if (bc < 8) sh = {sh[6:0], ds};
        bc++;
      end else if (mode != 0 && pscl && !cs) begin
        if (bc == 8) begin
          drv = 1'b0;
          if (mode == 1) begin
            ctrls.push_back(sh); blk = sh[3:1]; rw = sh[0];
            drv = attached && sh[7:4] == 4'hA;
          end else if (mode == 2) begin
            word = sh; drv = attached;
          end else if (mode == 3) begin
            mem[{blk, word}] = sh; drv = attached;
          end
        end else if (bc == 9) begin
          bc = 0; drv = 1'b0;
          mode = (mode == 1) ? (rw ? 4 : 2) : (mode == 2) ? 3 : (mode == 4) ? 0 : 5;
          if (mode == 4) begin
            rsh = mem[{blk, word}];
            drv = attached && !rsh[7];
          end
        end else if (mode == 4 && bc >= 1 && bc <= 7) begin
          drv = attached && !rsh[7 - bc];
        end
      end
      pscl = cs; psda = ds;
    end
  end

  task automatic run_txn(input logic w, input logic [10:0] a, input logic [7:0] d,
                         output int cyc, output logic [7:0] rv, output logic b1, output logic b2);
    @(negedge clk);
    bus.wr_req = w; bus.rd_req = !w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    b1 = bus.busy;
    cyc = 0;
    while (!bus.done && cyc < 60 * T) begin
      @(posedge clk); #1;
      cyc++;
    end
    rv = bus.rdata;
    @(posedge clk); #1;
    b2 = bus.busy;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b expected 1", scl); end
    n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1 (released)", sda); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_chk++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_basic();
    int cyc, s0; logic [7:0] rv; logic b1, b2;
    ctrls.delete(); s0 = starts;
    run_txn(1'b1, 11'h123, 8'h5A, cyc, rv, b1, b2);
    ref_mem[11'h123] = 8'h5A;
    n_chk++; if (cyc != 29 * T) begin n_fail++; $display("FAIL wr_len: got %0d clk expected %0d", cyc, 29 * T); end
    n_chk++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", b1); end
    n_chk++; if (b2 !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end: got %b expected 0", b2); end
    n_chk++; if (mem[11'h123] !== 8'h5A) begin n_fail++; $display("FAIL wr_mem: got %h expected 5a", mem[11'h123]); end
    n_chk++; if (ctrls.size() != 1 || ctrls[0] !== 8'hA2) begin n_fail++; $display("FAIL wr_ctrl: got %0d bytes first %h expected 1 byte a2", ctrls.size(), ctrls.size() > 0 ? ctrls[0] : 8'h00); end
    n_chk++; if (starts - s0 != 1) begin n_fail++; $display("FAIL wr_starts: got %0d expected 1", starts - s0); end
  endtask

  task automatic test_read_basic();
    int cyc; logic [7:0] rv; logic b1, b2;
    ctrls.delete();
    run_txn(1'b0, 11'h123, 8'h00, cyc, rv, b1, b2);
    last_rd = ref_mem[11'h123];
    n_chk++; if (cyc != 39 * T) begin n_fail++; $display("FAIL rd_len: got %0d clk expected %0d", cyc, 39 * T); end
    n_chk++; if (rv !== 8'h5A) begin n_fail++; $display("FAIL rd_data: got %h expected 5a", rv); end
    n_chk++; if (ctrls.size() != 2 || ctrls[0] !== 8'hA2 || ctrls[1] !== 8'hA3) begin n_fail++; $display("FAIL rd_ctrl: got %0d bytes expected a2,a3", ctrls.size()); end
    n_chk++; if (b2 !== 1'b0) begin n_fail++; $display("FAIL rd_busy_end: got %b expected 0", b2); end
  endtask

  task automatic test_boundary();
    int cyc; logic [7:0] rv; logic b1, b2;
    ctrls.delete();
    run_txn(1'b1, 11'h7FF, 8'hC3, cyc, rv, b1, b2);
    ref_mem[11'h7FF] = 8'hC3;
    n_chk++; if (ctrls.size() != 1 || ctrls[0] !== 8'hAE) begin n_fail++; $display("FAIL bnd_wctrl: got %0d bytes expected ae", ctrls.size()); end
    ctrls.delete();
    run_txn(1'b0, 11'h7FF, 8'h00, cyc, rv, b1, b2);
    last_rd = ref_mem[11'h7FF];
    n_chk++; if (ctrls.size() != 2 || ctrls[0] !== 8'hAE || ctrls[1] !== 8'hAF) begin n_fail++; $display("FAIL bnd_rctrl: got %0d bytes expected ae,af", ctrls.size()); end
    n_chk++; if (rv !== 8'hC3) begin n_fail++; $display("FAIL bnd_rdata: got %h expected c3", rv); end
    n_chk++; if (mem[11'h0FF] !== ref_mem[11'h0FF]) begin n_fail++; $display("FAIL bnd_0ff: got %h expected %h", mem[11'h0FF], ref_mem[11'h0FF]); end
  endtask

  task automatic test_random();
    int cyc; logic [7:0] rv, d; logic b1, b2; logic [10:0] a, b;
    for (int k = 0; k < 6; k++) begin
      a = 11'($urandom); d = 8'($urandom);
      ctrls.delete();
      run_txn(1'b1, a, d, cyc, rv, b1, b2);
      ref_mem[a] = d;
      n_chk++; if (cyc != 29 * T) begin n_fail++; $display("FAIL rnd_wlen: got %0d expected %0d", cyc, 29 * T); end
      n_chk++; if (mem[a] !== d) begin n_fail++; $display("FAIL rnd_wmem: addr %h got %h expected %h", a, mem[a], d); end
      n_chk++; if (ctrls.size() != 1 || ctrls[0] !== {4'hA, a[10:8], 1'b0}) begin n_fail++; $display("FAIL rnd_wctrl: addr %h got %0d bytes expected %h", a, ctrls.size(), {4'hA, a[10:8], 1'b0}); end
      b = k[0] ? a : 11'($urandom);
      ctrls.delete();
      run_txn(1'b0, b, 8'h00, cyc, rv, b1, b2);
      last_rd = ref_mem[b];
      n_chk++; if (cyc != 39 * T) begin n_fail++; $display("FAIL rnd_rlen: got %0d expected %0d", cyc, 39 * T); end
      n_chk++; if (rv !== ref_mem[b]) begin n_fail++; $display("FAIL rnd_rdata: addr %h got %h expected %h", b, rv, ref_mem[b]); end
      n_chk++; if (ctrls.size() != 2 || ctrls[1] !== {4'hA, b[10:8], 1'b1}) begin n_fail++; $display("FAIL rnd_rctrl: addr %h got %0d bytes expected %h", b, ctrls.size(), {4'hA, b[10:8], 1'b1}); end
    end
  endtask

  task automatic test_collision();
    int s0, d0;
    ctrls.delete(); s0 = starts; d0 = dones;
    @(negedge clk);
    bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.addr = 11'h123; bus.wdata = 8'h3C;
    @(posedge clk); #1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    ref_mem[11'h123] = 8'h3C;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL col_busy: got %b expected 1", bus.busy); end
    bus.rd_req = 1'b1; bus.addr = 11'h456;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    repeat (45 * T) @(posedge clk);
    #1;
    n_chk++; if (dones - d0 != 1) begin n_fail++; $display("FAIL col_dones: got %0d expected 1", dones - d0); end
    n_chk++; if (starts - s0 != 1) begin n_fail++; $display("FAIL col_starts: got %0d expected 1", starts - s0); end
    n_chk++; if (ctrls.size() != 1 || ctrls[0] !== 8'hA2) begin n_fail++; $display("FAIL col_ctrl: got %0d bytes expected a2", ctrls.size()); end
    n_chk++; if (mem[11'h123] !== 8'h3C) begin n_fail++; $display("FAIL col_mem: got %h expected 3c", mem[11'h123]); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL col_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [7:0] rv; logic b1, b2;
    @(negedge clk);
    bus.wr_req = 1'b1; bus.addr = 11'h2C5; bus.wdata = 8'h96;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    repeat (13 * T) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_scl: got %b expected 1", scl); end
    n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rst_sda: got %b expected 1 (released)", sda); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_chk++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h expected 00", bus.rdata); end
    last_rd = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    n_chk++; if (mem[11'h2C5] !== ref_mem[11'h2C5]) begin n_fail++; $display("FAIL rst_nowrite: got %h expected %h", mem[11'h2C5], ref_mem[11'h2C5]); end
    run_txn(1'b1, 11'h2C5, 8'h96, cyc, rv, b1, b2);
    ref_mem[11'h2C5] = 8'h96;
    n_chk++; if (cyc != 29 * T) begin n_fail++; $display("FAIL rst_wlen: got %0d expected %0d", cyc, 29 * T); end
    n_chk++; if (mem[11'h2C5] !== 8'h96) begin n_fail++; $display("FAIL rst_wmem: got %h expected 96", mem[11'h2C5]); end
  endtask

  task automatic test_no_slave();
    int cyc, p0; logic [7:0] rv; logic b1, b2;
    attached = 1'b0; p0 = stops;
    run_txn(1'b0, 11'h0AB, 8'h00, cyc, rv, b1, b2);
    n_chk++; if (stops - p0 != 1) begin n_fail++; $display("FAIL ns_stop: got %0d expected 1", stops - p0); end
`ifdef EEPROM_I2C_MASTER_ACK_CHECK_EN
    n_chk++; if (cyc != 11 * T) begin n_fail++; $display("FAIL ns_len: got %0d expected %0d", cyc, 11 * T); end
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ns_err: got %b expected 1", bus.err); end
    n_chk++; if (rv !== last_rd) begin n_fail++; $display("FAIL ns_rdata: got %h expected %h", rv, last_rd); end
`else
    n_chk++; if (cyc != 39 * T) begin n_fail++; $display("FAIL ns_len: got %0d expected %0d", cyc, 39 * T); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ns_err: got %b expected 0", bus.err); end
    n_chk++; if (rv !== 8'hFF) begin n_fail++; $display("FAIL ns_rdata: got %h expected ff", rv); end
    last_rd = 8'hFF;
`endif
    attached = 1'b1;
    run_txn(1'b1, 11'h0AB, 8'h77, cyc, rv, b1, b2);
    ref_mem[11'h0AB] = 8'h77;
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ns_err_clr: got %b expected 0", bus.err); end
    n_chk++; if (mem[11'h0AB] !== 8'h77) begin n_fail++; $display("FAIL ns_wmem: got %h expected 77", mem[11'h0AB]); end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);
    test_reset();
    test_write_basic();
    test_read_basic();
    test_boundary();
    test_random();
    test_collision();
    test_reset_mid();
    test_no_slave();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
